bus_fabric: RTL and testbench
=============================

// Module: bus_fabric
// PURPOSE
//  Parametrised data-bus interconnect between the core data port and NDEV peripherals.
//  Decodes read/write requests against per-device address windows and issues one-cycle device strobes.
//  Waits for a per-device ack and returns registered read data, a done pulse, or an error.
//  Errors cover unmapped addresses, misalignment, illegal mode and ack timeout.
// PARAMETERS
//  NDEV     4                  number of device slots
//  BASES    {NDEV{32'h0}}      packed NDEV*32; slot i window base = BASES[32*i+:32]
//  MASKS    {NDEV{6'd12}}      packed NDEV*6; slot i offset bits; window = 2**MASKS[i] bytes
//  TIMEOUT  16                 cycles to wait for ack before error (>=1); TW=$clog2(TIMEOUT+1)
// PORTS
//  clk          in   1         clock
//  rst_n        in   1         asynchronous active-low reset
//  clk_enable   in   1         CMU enable; FSM, counter and ack sampling advance only when 1
//  r_en         in   1         read request
//  r_addr       in   32        read byte address
//  w_en         in   1         write request
//  w_addr       in   32        write byte address
//  mode         in   2         00 byte, 01 half, 10 word, 11 illegal
//  w_data       in   32        write data
//  r_data       out  32        read data; valid while done=1, held until next done
//  busy         out  1         transaction in flight (state != IDLE)
//  done         out  1         one-cycle completion pulse
//  err          out  1         qualifies done: transaction failed
//  err_addr     out  32        address of last failed transaction (sticky until next error)
//  dev_r_en     out  NDEV      one-hot read strobe
//  dev_w_en     out  NDEV      one-hot write strobe
//  dev_addr     out  32        in-window offset: addr & (2**MASKS[sel]-1)
//  dev_mode     out  2         registered mode
//  dev_w_data   out  32        registered write data
//  dev_r_data   in   NDEV*32   packed device read data
//  dev_ack      in   NDEV      device completion; may assert in the strobe cycle
// BEHAVIOUR
//  Reset: state IDLE; r_data, err_addr, dev_addr, dev_w_data = 0; dev_mode = 0; all strobes, busy, done, err = 0.
//  Reset mid-transaction: strobes drop immediately (async); the transaction is lost; no done is issued.
//  Decode: slot i hits when addr>>MASKS[i] == BASES[i]>>MASKS[i]. Lowest hitting index wins.
//  FSM states: IDLE, ISSUE, WAIT, DONE. Transitions occur only on edges where clk_enable=1.
//  IDLE: a request is accepted if r_en^w_en. The address used is r_addr or w_addr accordingly.
//   Hit and aligned -> latch sel, offset, mode, data -> ISSUE.
//   Miss, mode=11, (mode=01 & addr[0]), or (mode=10 & addr[1:0]!=0) -> DONE with err=1; no strobe.
//   r_en&w_en together -> DONE with err=1, err_addr=w_addr; no strobe.
//  ISSUE: dev_*_en[sel] = 1 for this state only, ANDed with clk_enable (a device never sees a stalled duplicate strobe).
//   Ack seen -> DONE. Otherwise -> WAIT.
//  WAIT: strobes low. On dev_ack[sel] -> DONE; r_data <= dev_r_data[sel] (reads).
//   Timeout counter starts at 0 in ISSUE and increments per enabled cycle.
//   Counter == TIMEOUT-1 without ack -> DONE with err=1, r_data=0.
//   Acks from unselected slots are ignored.
//  DONE: done=1, err as decided; err_addr latched on error -> IDLE. A request in the DONE cycle is ignored.
//  Requests while busy=1 are ignored (not queued). The core holds its request until done.
//  Latency: request edge N; strobe cycle N+1; ack same cycle -> done at N+2. Decode error -> done at N+1.
//  Write r_data unchanged. Outputs r_data, err, done are registered. The strobe is state-decoded plus the clk_enable gate.
// TESTING
//  Read slot1 (BASE 0x10,MASK 4) @0x14 word; ack in strobe cycle, data 0xCAFEF00D -> dev_r_en=0010, dev_addr=4, done 2 cycles later, r_data=0xCAFEF00D, err=0.
//  Write @0x1000 (slot0 BASE 0x1000,MASK 12), half, data 0xBEEF; ack after 3 cycles -> one dev_w_en[0] pulse, dev_addr=0, done 5 cycles after request, err=0.
//  Read @0x8000_0000 (unmapped) -> no strobe, done+err next cycle, err_addr=0x8000_0000; word @0x1002 -> misalign err.
//  No ack, TIMEOUT=16 -> done+err exactly 16 enabled cycles after strobe; r_data=0.
//  clk_enable low for 5 cycles in ISSUE -> strobe seen only on enabled cycle; timeout count frozen; r_en&w_en -> err.
//  rst_n low in WAIT -> strobes/busy 0 at once; after release IDLE; next read completes normally.

Source files
------------

// File: rtl/bus_fabric.sv
// bus_fabric: decodes core read/write requests onto NDEV address windows, issues
// one-cycle strobes, and returns registered data, a done pulse or an error.
module bus_fabric #(
  parameter int                 NDEV    = 4,
  parameter logic [NDEV*32-1:0] BASES   = {NDEV{32'h0}},
  parameter logic [NDEV*6-1:0]  MASKS   = {NDEV{6'd12}},
  parameter int                 TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_enable,
  input  logic               r_en,
  input  logic [31:0]        r_addr,
  input  logic               w_en,
  input  logic [31:0]        w_addr,
  input  logic [1:0]         mode,
  input  logic [31:0]        w_data,
  output logic [31:0]        r_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        err_addr,
  output logic [NDEV-1:0]    dev_r_en,
  output logic [NDEV-1:0]    dev_w_en,
  output logic [31:0]        dev_addr,
  output logic [1:0]         dev_mode,
  output logic [31:0]        dev_w_data,
  input  logic [NDEV*32-1:0] dev_r_data,
  input  logic [NDEV-1:0]    dev_ack
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = NDEV > 1 ? $clog2(NDEV) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sel_q, sel_d, hit_sel;
  logic [31:0] req_addr, hit_off;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, eaddr_q, eaddr_d, full_q, full_d;
  logic [1:0] mode_q, mode_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic wr_q, wr_d, err_q, err_d, hit_any, misalign, ack, stb;
  logic [NDEV-1:0] onehot;
  // Descending scan so the lowest hitting slot is the one left standing.
  always_comb begin
    req_addr = w_en ? w_addr : r_addr;
    hit_any = 1'b0;
    hit_sel = '0;
    hit_off = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if ((req_addr >> MASKS[6*i+:6]) == (BASES[32*i+:32] >> MASKS[6*i+:6])) begin
        hit_any = 1'b1;
        hit_sel = SW'(i);
        hit_off = req_addr & ((32'd1 << MASKS[6*i+:6]) - 32'd1);
      end
    end
  end
  assign misalign = (mode == 2'b11) | ((mode == 2'b01) & req_addr[0]) | ((mode == 2'b10) & (|req_addr[1:0]));
  assign ack = dev_ack[sel_q];
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    eaddr_d = eaddr_q;
    full_d = full_q;
    mode_d = mode_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    err_d = err_q;
    if (clk_enable) begin
      case (state_q)
        IDLE: begin
          if (r_en & w_en) begin
            state_d = DONE;
            err_d = 1'b1;
            eaddr_d = w_addr;
          end else if (r_en | w_en) begin
            if (!hit_any || misalign) begin
              state_d = DONE;
              err_d = 1'b1;
              eaddr_d = req_addr;
            end else begin
              state_d = ISSUE;
              sel_d = hit_sel;
              addr_d = hit_off;
              mode_d = mode;
              wdata_d = w_data;
              wr_d = w_en;
              full_d = req_addr;
              cnt_d = '0;
            end
          end
        end
        ISSUE, WAIT: begin
          if (ack) begin
            state_d = DONE;
            rdata_d = wr_q ? rdata_q : dev_r_data[32*sel_q+:32];
          end else if (cnt_q == TW'(TIMEOUT - 1)) begin
            state_d = DONE;
            err_d = 1'b1;
            eaddr_d = full_q;
            rdata_d = wr_q ? rdata_q : '0;
          end else begin
            state_d = WAIT;
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          err_d = 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      eaddr_q <= '0;
      full_q <= '0;
      mode_q <= '0;
      cnt_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      eaddr_q <= eaddr_d;
      full_q <= full_d;
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      err_q <= err_d;
    end
  end
  // Gated by clk_enable so a stalled ISSUE never repeats the strobe.
  assign stb = (state_q == ISSUE) & clk_enable;
  assign onehot = NDEV'(1) << sel_q;
  assign dev_r_en = (stb & ~wr_q) ? onehot : '0;
  assign dev_w_en = (stb & wr_q) ? onehot : '0;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign err = err_q;
  assign r_data = rdata_q;
  assign err_addr = eaddr_q;
  assign dev_addr = addr_q;
  assign dev_mode = mode_q;
  assign dev_w_data = wdata_q;
endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: directed table, stall/reset sequences and random traffic
// against a window-arithmetic reference model of bus_fabric.
module tb_bus_fabric;
  localparam int NDEV = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0, rst_n = 1'b0, clk_enable = 1'b1;
  logic r_en = 1'b0, w_en = 1'b0;
  logic [31:0] r_addr = '0, w_addr = '0, w_data = '0;
  logic [1:0] mode = '0;
  logic [31:0] r_data, err_addr, dev_addr, dev_w_data;
  logic busy, done, err;
  logic [NDEV-1:0] dev_r_en, dev_w_en, dev_ack = '0;
  logic [1:0] dev_mode;
  logic [NDEV*32-1:0] dev_r_data = '0;

  bus_fabric #(
    .NDEV(NDEV),
    .BASES({32'h2000, 32'h2000, 32'h10, 32'h1000}),
    .MASKS({6'd12, 6'd8, 6'd4, 6'd12}),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .r_en(r_en), .r_addr(r_addr), .w_en(w_en), .w_addr(w_addr),
    .mode(mode), .w_data(w_data), .r_data(r_data), .busy(busy),
    .done(done), .err(err), .err_addr(err_addr),
    .dev_r_en(dev_r_en), .dev_w_en(dev_w_en), .dev_addr(dev_addr),
    .dev_mode(dev_mode), .dev_w_data(dev_w_data),
    .dev_r_data(dev_r_data), .dev_ack(dev_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rd, wr;
    logic [31:0] raddr, waddr;
    logic [1:0] md;
    logic [31:0] wd;
    int dly;
    logic [31:0] dd;
    int lat;
    bit err, rk;
    logic [31:0] rdata, eaddr;
    logic [3:0] rs, ws;
    logic [31:0] off;
  } vec_t;

  longint base_t[4] = '{64'h1000, 64'h10, 64'h2000, 64'h2000};
  longint size_t[4] = '{64'd4096, 64'd16, 64'd256, 64'd4096};
  int n_cmp = 0, n_bad = 0;
  bit m_rk = 1'b1;
  logic [31:0] m_rdata = '0, m_eaddr = '0;
  vec_t dir[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int find_slot(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (longint'(a) >= base_t[i] && longint'(a) < base_t[i] + size_t[i]) return i;
    return -1;
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t e = v;
    logic [31:0] a = v.wr ? v.waddr : v.raddr;
    int s = find_slot(a);
    e.rs = '0; e.ws = '0; e.off = '0; e.rk = 1'b0; e.rdata = '0;
    if ((v.rd && v.wr) || s < 0 || v.md == 2'd3 || (a % (32'd1 << v.md)) != 0) begin
      e.lat = 1; e.err = 1'b1; e.eaddr = a;
    end else begin
      e.rs = v.rd ? 4'(1 << s) : 4'd0;
      e.ws = v.wr ? 4'(1 << s) : 4'd0;
      e.off = 32'(longint'(a) - base_t[s]);
      if (v.dly >= 0 && v.dly < TIMEOUT) begin
        e.lat = 2 + v.dly; e.err = 1'b0; e.eaddr = m_eaddr;
        e.rk = v.rd ? 1'b1 : m_rk;
        e.rdata = v.rd ? v.dd : m_rdata;
      end else begin
        e.lat = TIMEOUT + 1; e.err = 1'b1; e.eaddr = a;
        e.rk = v.rd;
        e.rdata = '0;
      end
    end
    return e;
  endfunction

  task automatic run_vec(input vec_t v);
    int cd = -1, nstb = 0;
    bit seen = 1'b0;
    logic [3:0] tgt = v.rs | v.ws, rs_acc = '0, ws_acc = '0;
    logic [31:0] off_s = '0, wd_s = '0;
    logic [1:0] md_s = '0;
    @(negedge clk);
    for (int i = 0; i < NDEV; i++) dev_r_data[32*i+:32] = tgt[i] ? v.dd : $urandom;
    r_en = v.rd; w_en = v.wr; r_addr = v.raddr; w_addr = v.waddr;
    mode = v.md; w_data = v.wd; dev_ack = '0;
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      @(negedge clk);
      if (|dev_r_en || |dev_w_en) begin
        nstb++; rs_acc |= dev_r_en; ws_acc |= dev_w_en;
        off_s = dev_addr; md_s = dev_mode; wd_s = dev_w_data; cd = v.dly;
      end
      if (done) begin
        seen = 1'b1;
        chk("latency", cyc, v.lat);
        chk("err", err, v.err);
        chk("err_addr", err_addr, v.eaddr);
        if (v.rk) chk("r_data", r_data, v.rdata);
        r_en = 1'b0; w_en = 1'b0; dev_ack = '0;
      end else begin
        dev_ack = (4'($urandom) & ~tgt) | ((cd == 0) ? tgt : 4'd0);
        if (cd >= 0) cd--;
      end
    end
    if (!seen) begin
      chk("done_within_budget", 32'd0, 32'd1);
      r_en = 1'b0; w_en = 1'b0; dev_ack = '0;
    end
    chk("rd_strobe", rs_acc, v.rs);
    chk("wr_strobe", ws_acc, v.ws);
    chk("strobe_count", nstb, (tgt != 0) ? 1 : 0);
    if (tgt != 0) begin
      chk("dev_addr", off_s, v.off);
      chk("dev_mode", md_s, v.md);
      if (v.wr) chk("dev_w_data", wd_s, v.wd);
    end
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("idle_after", busy, 1'b0);
    m_rk = v.rk; m_rdata = v.rdata; m_eaddr = v.eaddr;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dir[0]  = '{1, 0, 32'h14, 0, 2'd2, 0, 0, 32'hCAFEF00D, 2, 0, 1, 32'hCAFEF00D, 0, 4'b0010, 0, 32'h4};
    dir[1]  = '{0, 1, 0, 32'h1000, 2'd1, 32'hBEEF, 3, 0, 5, 0, 1, 32'hCAFEF00D, 0, 0, 4'b0001, 0};
    dir[2]  = '{1, 0, 32'h8000_0000, 0, 2'd2, 0, 0, 0, 1, 1, 0, 0, 32'h8000_0000, 0, 0, 0};
    dir[3]  = '{1, 0, 32'h1002, 0, 2'd2, 0, 0, 0, 1, 1, 0, 0, 32'h1002, 0, 0, 0};
    dir[4]  = '{1, 0, 32'h1001, 0, 2'd1, 0, 0, 0, 1, 1, 0, 0, 32'h1001, 0, 0, 0};
    dir[5]  = '{1, 0, 32'h1003, 0, 2'd0, 0, 1, 32'h11223344, 3, 0, 1, 32'h11223344, 32'h1001, 4'b0001, 0, 32'h3};
    dir[6]  = '{1, 0, 32'h2010, 0, 2'd3, 0, 0, 0, 1, 1, 0, 0, 32'h2010, 0, 0, 0};
    dir[7]  = '{1, 0, 32'h2010, 0, 2'd2, 0, 0, 32'hA5A5, 2, 0, 1, 32'hA5A5, 32'h2010, 4'b0100, 0, 32'h10};
    dir[8]  = '{1, 0, 32'h2F00, 0, 2'd2, 0, 15, 32'h5A5A1234, 17, 0, 1, 32'h5A5A1234, 32'h2010, 4'b1000, 0, 32'hF00};
    dir[9]  = '{1, 1, 32'h14, 32'h1004, 2'd2, 1, 0, 0, 1, 1, 0, 0, 32'h1004, 0, 0, 0};
    dir[10] = '{1, 0, 32'h1F, 0, 2'd0, 0, -1, 0, 17, 1, 1, 0, 32'h1F, 4'b0010, 0, 32'hF};
    dir[11] = '{0, 1, 0, 32'h1008, 2'd2, 32'h12345678, 16, 0, 17, 1, 0, 0, 32'h1008, 0, 4'b0001, 32'h8};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_r_data", r_data, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_dev_addr", dev_addr, 32'h0);
    chk("rst_dev_mode", dev_mode, 2'd0);
    chk("rst_dev_w_data", dev_w_data, 32'h0);
    chk("rst_strobes", {dev_r_en, dev_w_en}, 8'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(dir[i]);

    // Stall in ISSUE, then let the timeout run with a ragged enable.
    begin
      int k = 0;
      bit got = 1'b0;
      logic [7:0] stb_any = '0;
      @(negedge clk);
      dev_r_data[63:32] = 32'h77777777;
      r_en = 1'b1; r_addr = 32'h18; mode = 2'd2; dev_ack = '0;
      @(posedge clk);
      #1 clk_enable = 1'b0;
      repeat (5) begin
        @(negedge clk);
        stb_any |= {dev_r_en, dev_w_en};
      end
      chk("stall_no_strobe", stb_any, 8'h0);
      chk("stall_busy", busy, 1'b1);
      clk_enable = 1'b1;
      #1 chk("enabled_strobe", dev_r_en, 4'b0010);
      stb_any = '0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(posedge clk);
        if (clk_enable) k++;
        @(negedge clk);
        stb_any |= {dev_r_en, dev_w_en};
        if (done) got = 1'b1;
        else clk_enable = ($urandom_range(0, 2) != 0);
      end
      chk("stall_done_seen", got, 1'b1);
      chk("stall_timeout_edges", k, TIMEOUT);
      chk("stall_err", err, 1'b1);
      chk("stall_r_data", r_data, 32'h0);
      chk("stall_err_addr", err_addr, 32'h18);
      chk("stall_wait_strobes", stb_any, 8'h0);
      clk_enable = 1'b1; r_en = 1'b0;
      @(negedge clk);
      chk("stall_done_clear", done, 1'b0);
      m_rk = 1'b1; m_rdata = '0; m_eaddr = 32'h18;
    end

    // Asynchronous reset while waiting for an ack.
    @(negedge clk);
    r_en = 1'b1; r_addr = 32'h1010; mode = 2'd2; dev_ack = '0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_busy", busy, 1'b0);
    chk("areset_done", done, 1'b0);
    chk("areset_strobes", {dev_r_en, dev_w_en}, 8'h0);
    chk("areset_err_addr", err_addr, 32'h0);
    @(negedge clk);
    r_en = 1'b0; rst_n = 1'b1;
    m_rk = 1'b1; m_rdata = '0; m_eaddr = '0;
    run_vec(dir[0]);

    for (int n = 0; n < 40; n++) begin
      vec_t v;
      int s = $urandom_range(0, 4);
      int r = $urandom_range(0, 7);
      logic [31:0] a;
      a = (s == 4) ? (32'h8000_0000 | $urandom) : 32'(base_t[s] + longint'($urandom_range(0, int'(size_t[s]) - 1)));
      v.rd = ($urandom_range(0, 9) == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      v.wr = v.rd ? ($urandom_range(0, 9) == 0) : 1'b1;
      v.raddr = (v.rd && !v.wr) ? a : $urandom;
      v.waddr = v.wr ? a : $urandom;
      v.md = (r < 7) ? 2'(r % 3) : 2'd3;
      v.wd = $urandom;
      v.dd = $urandom;
      v.dly = ($urandom_range(0, 9) == 0) ? -1 :
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 17)) : int'($urandom_range(0, 2));
      run_vec(model(v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
